// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-addressed data-memory responder for the CPU load/store port.
//   One request is accepted at a time. It is held for WAIT_CYCLES wait states
//   and then committed to the internal RAM. Data and status are then returned
//   over a valid/ready response channel.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset (RAM contents are kept)
//   req_valid  : CPU presents a request
//   req_ready  : responder can accept a request (IDLE and not in reset)
//   req_we     : 1 = store, 0 = load
//   req_addr   : byte address
//   req_wdata  : store data
//   req_be     : byte enables, bit i covers wdata[8i+7:8i]
//   resp_valid : response available
//   resp_ready : CPU takes the response
//   resp_rdata : load data, 0 for stores and errors
//   resp_err   : request was misaligned or out of range
//   busy       : high whenever the FSM is not IDLE
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A request is in error when it is not word aligned or points past the RAM.
  function automatic logic addr_err_f(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> (ADDR_W + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic        lat_we_r;
  logic [31:0] lat_addr_r;
  logic [31:0] lat_wdata_r;
  logic [3:0]  lat_be_r;
  logic        resp_valid_r, resp_valid_nx;
  logic [31:0] resp_rdata_r, resp_rdata_nx;
  logic        resp_err_r, resp_err_nx;

  logic        accept_s;
  logic        commit_s;
  logic        mem_we_s;
  logic        err_s;
  logic [ADDR_W-1:0] idx_s;
  logic [31:0] rd_word_s;

  logic [31:0] mem [0:DEPTH-1];

  assign idx_s     = lat_addr_r[ADDR_W+1:2];
  assign rd_word_s = mem[idx_s];
  assign err_s     = addr_err_f(lat_addr_r);

  assign req_ready  = (state_r == ST_IDLE) & ~reset;
  assign busy       = (state_r != ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Next-state and response-register logic of the request FSM.
  always_comb begin
    state_nx      = state_r;
    cnt_nx        = cnt_r;
    resp_valid_nx = resp_valid_r;
    resp_rdata_nx = resp_rdata_r;
    resp_err_nx   = resp_err_r;
    accept_s      = 1'b0;
    commit_s      = 1'b0;
    mem_we_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept_s = 1'b1;
          cnt_nx   = 4'(WAIT_CYCLES);
          state_nx = ST_WAIT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_nx = cnt_r - 4'd1;
        end else begin
          // Commit edge: the only RAM access happens here, so a load
          // sees the RAM word directly with no same-edge write to bypass.
          commit_s      = 1'b1;
          mem_we_s      = lat_we_r & ~err_s & ~reset;
          state_nx      = ST_RESP;
          resp_valid_nx = 1'b1;
          resp_err_nx   = err_s;
          if (err_s || lat_we_r) begin
            resp_rdata_nx = 32'd0;
          end else begin
            resp_rdata_nx = rd_word_s;
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_nx = 1'b0;
          resp_rdata_nx = 32'd0;
          resp_err_nx   = 1'b0;
          state_nx      = ST_IDLE;
        end else begin
          state_nx = ST_RESP;
        end
      end
      default: begin
        state_nx      = ST_IDLE;
        resp_valid_nx = 1'b0;
        resp_rdata_nx = 32'd0;
        resp_err_nx   = 1'b0;
      end
    endcase
  end

  // State, wait counter, latched request and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      lat_we_r     <= 1'b0;
      lat_addr_r   <= 32'd0;
      lat_wdata_r  <= 32'd0;
      lat_be_r     <= 4'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      resp_valid_r <= resp_valid_nx;
      resp_rdata_r <= resp_rdata_nx;
      resp_err_r   <= resp_err_nx;
      if (accept_s) begin
        lat_we_r    <= req_we;
        lat_addr_r  <= req_addr;
        lat_wdata_r <= req_wdata;
        lat_be_r    <= req_be;
      end
    end
  end

  // Data RAM write port with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be_r[i]) begin
          mem[idx_s][8*i +: 8] <= lat_wdata_r[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the slave end of the CPU load/store interface.
- Accepts one request at a time over a valid/ready channel and holds it for a programmable number of wait states.
- Commits the write or performs the read, then returns data and status over a valid/ready response channel.
- Sits between the MIPS datapath's load/store path and the on-chip data RAM; replaces the zero-latency data memory for wait-state testing.

Parameters:
ADDR_W, 10, word-index width; RAM holds 2**ADDR_W 32-bit words
WAIT_CYCLES, 2, wait states between request acceptance and access commit (0..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  CPU presents a request
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i covers wdata[8i+7:8i]
resp_valid  output  1  response available
resp_ready  input  1  CPU takes the response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  request was misaligned or out of range
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset: state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - req_ready=0 while reset is high.
  - RAM contents are not reset.
- req_ready = (state==IDLE) & ~reset.
- IDLE:
  - On an edge with req_valid & req_ready, latch we/addr/wdata/be, load counter=WAIT_CYCLES, go to WAIT.
  - A request is never accepted in the same cycle a response completes.
- WAIT:
  - If counter!=0, decrement it.
  - If counter==0, commit the access on that edge, go to RESP, and set resp_valid=1.
- Latency: acceptance at edge T gives resp_valid high after edge T+1+WAIT_CYCLES (T+1 for WAIT_CYCLES=0).
- Commit rules:
  - Error if addr[1:0]!=0 or addr[31:ADDR_W+2]!=0. Then resp_err=1, resp_rdata=0, no RAM write.
  - Store: RAM[addr[ADDR_W+1:2]] updates only the enabled bytes; resp_rdata=0. be=0000 is a legal no-op store.
  - Load: resp_rdata = full word at commit, after any same-edge effects. Byte enables are ignored for loads.
- RESP:
  - resp_valid, resp_rdata and resp_err stay stable until an edge with resp_ready=1.
  - On that edge: resp_valid=0, resp_rdata=0, resp_err=0, go to IDLE.
  - resp_ready asserted outside RESP has no effect.
- Request inputs are don't-care outside IDLE. Changes during WAIT do not affect the latched request.
- Read-after-write: a load accepted after a store's response completes returns the stored data.
- Reset mid-operation:
  - Reset asserted in WAIT aborts the request; the pending store is not committed.
  - Reset in RESP drops the response; a store already committed stays in the RAM.

Test Plan:
- Store then load with WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, be=1111, resp_ready=1 -> resp_valid 3 edges after acceptance, err=0, rdata=0. Then load 0x10 -> rdata=0xDEADBEEF 3 edges after acceptance.
- Byte-enable merge: store 0x20=0x11223344 be=1111, then store 0x20=0xAABBCCDD be=0101, then load 0x20 -> 0x11BB33DD.
- Errors: load 0x13 -> resp_err=1, rdata=0. Store 0x00001000 (ADDR_W=10) -> resp_err=1, and a later load of 0x0 returns the prior contents unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, rdata and err stable, req_ready=0, and a req_valid pulse is ignored. Drop to IDLE one edge after resp_ready=1.
- WAIT_CYCLES=0 build: acceptance at edge T -> resp_valid after T+1. Back-to-back requests with resp_ready tied high accept one request every 3 cycles.
- Async reset mid-WAIT: store 0x40=0x5 then reset during WAIT -> all outputs 0 immediately. After release, load 0x40 returns the previously written value (preload 0x40=0x9, expect 0x9).
